// File: rtl/matmul_result_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matmul_result_streamer                                        |
// | Purpose  : snapshots the multiplier's NxN result and streams it out      |
// |            row-major over a valid/ready interface.                       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module matmul_result_streamer #(
  parameter  int N          = 8,
  parameter  int DATA_WIDTH = 8,
  localparam int OW         = 2 * DATA_WIDTH,
  localparam int RW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mm_done,
  input  logic [N*N*OW-1:0] c_flat,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OW-1:0]     m_data,
  output logic [RW-1:0]     m_row,
  output logic [RW-1:0]     m_col,
  output logic              m_last_col,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clear_overrun
);

  localparam int          c_ne   = N * N;
  localparam int          c_iw   = (c_ne > 1) ? $clog2(c_ne) : 1;
  localparam logic [RW-1:0] c_last = RW'(N - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [OW-1:0]     r_snap [c_ne];
  logic [RW-1:0]     r_row;
  logic [RW-1:0]     r_col;
  logic [c_iw-1:0]   r_idx;
  logic              r_overrun;

  logic              w_beat;
  logic              w_final;
  logic              w_start;
  logic              w_ovr_evt;

  assign w_beat    = (r_state == STREAM) && m_ready;
  assign w_final   = w_beat && (r_row == c_last) && (r_col == c_last);
  // A done pulse is only taken when the buffer is free or being freed this edge.
  assign w_start   = mm_done && ((r_state == IDLE) || w_final);
  assign w_ovr_evt = mm_done && (r_state == STREAM) && !w_final;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    m_valid    = 1'b0;
    busy       = 1'b0;
    m_data     = '0;
    m_row      = '0;
    m_col      = '0;
    m_last_col = 1'b0;
    m_last     = 1'b0;
    if (w_start)      w_next = STREAM;
    else if (w_final) w_next = IDLE;
    if (r_state == STREAM) begin
      m_valid    = 1'b1;
      busy       = 1'b1;
      m_data     = r_snap[r_idx];
      m_row      = r_row;
      m_col      = r_col;
      m_last_col = (r_col == c_last);
      m_last     = (r_col == c_last) && (r_row == c_last);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < c_ne; e++) r_snap[e] <= '0;
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (w_start) begin
      for (int e = 0; e < c_ne; e++) r_snap[e] <= c_flat[e*OW +: OW];
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (w_final) begin
      r_row <= '0;
      r_col <= '0;
      r_idx <= '0;
    end else if (w_beat) begin
      r_idx <= r_idx + 1'b1;
      if (r_col == c_last) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Set has priority over clear so a coincident overrun is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_overrun <= 1'b0;
    else if (w_ovr_evt)     r_overrun <= 1'b1;
    else if (clear_overrun) r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;

endmodule
`default_nettype wire
